// File: rtl/vga_draw_arbiter_pkg.sv
// Shared constants, types and helpers for the VGA draw arbiter.
// Address and range helpers are kept here so every stage agrees on the screen geometry.
package vga_draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COORD_W  = 15;
  localparam int COLOUR_W = 9;

  localparam logic [COLOUR_W-1:0] TRANSPARENT_COLOUR = 9'b111_000_111;

  typedef enum logic [1:0] {
    SRC_ERASE = 2'd0,
    SRC_TOWER = 2'd1,
    SRC_CAR   = 2'd2
  } src_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic                valid;
    src_t                src;
    logic [COORD_W-1:0]  coord;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  function automatic logic in_range(input logic [COORD_W-1:0] c);
    return (c[7:0] < 8'(SCREEN_W)) && (c[14:8] < 7'(SCREEN_H));
  endfunction

  // y*160 + x written as shifts so no multiplier is inferred.
  function automatic logic [COORD_W-1:0] bg_addr(input logic [COORD_W-1:0] c);
    logic [COORD_W-1:0] y;
    y = {8'd0, c[14:8]};
    return (y << 7) + (y << 5) + {7'd0, c[7:0]};
  endfunction

  function automatic src_t next_src(input src_t s);
    src_t n;
    case (s)
      SRC_ERASE: n = SRC_TOWER;
      SRC_TOWER: n = SRC_CAR;
      default:   n = SRC_ERASE;
    endcase
    return n;
  endfunction

  function automatic src_t onehot_to_src(input logic [2:0] g);
    src_t s;
    case (g)
      3'b010:  s = SRC_TOWER;
      3'b100:  s = SRC_CAR;
      default: s = SRC_ERASE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin pick: the requester after i_last wins,
// and i_last itself is considered only when nobody else is asking.
module rr_arbiter3
  import vga_draw_pkg::*;
(
  input  logic [2:0] i_req,
  input  src_t       i_last,
  output logic [2:0] o_grant,
  output logic       o_valid
);

  src_t w_first;
  src_t w_second;

  always_comb begin
    w_first  = next_src(i_last);
    w_second = next_src(w_first);
    o_grant  = 3'b000;
    if (i_req[w_first]) begin
      o_grant[w_first] = 1'b1;
    end else if (i_req[w_second]) begin
      o_grant[w_second] = 1'b1;
    end else if (i_req[i_last]) begin
      o_grant[i_last] = 1'b1;
    end
    o_valid = |i_req;
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Shares the VGA write port between erase, tower and car drawers with burst round-robin.
// Define VGA_DRAW_ARB_TRANSPARENT_EN to drop tower/car pixels matching TRANSPARENT_COLOUR.
module vga_draw_arbiter
  import vga_draw_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                arb_enable,
  input  logic                erase_req,
  input  logic                tower_req,
  input  logic                car_req,
  input  logic [COORD_W-1:0]  erase_coord,
  input  logic [COORD_W-1:0]  tower_coord,
  input  logic [COORD_W-1:0]  car_coord,
  input  logic [COLOUR_W-1:0] tower_colour,
  input  logic [COLOUR_W-1:0] car_colour,
  output logic                erase_ack,
  output logic                tower_ack,
  output logic                car_ack,
  output logic [COORD_W-1:0]  mem_add,
  input  logic [COLOUR_W-1:0] mem_q,
  output logic [COORD_W-1:0]  coordinates,
  output logic [COLOUR_W-1:0] colours,
  output logic                VGA_write_enable,
  output logic                busy
);

  state_t              r_state;
  src_t                r_owner;
  src_t                r_last_owner;
  logic [COORD_W-1:0]  r_mem_add;
  pixel_t              r_s1;
  pixel_t              r_s2;

  logic [2:0]          w_req;
  logic                w_owner_req;
  logic                w_accept;
  src_t                w_rr_last;
  logic [2:0]          w_grant;
  logic                w_grant_valid;
  src_t                w_grant_src;
  logic [COORD_W-1:0]  w_in_coord;
  logic [COLOUR_W-1:0] w_in_colour;
  logic                w_in_range;
  logic                w_keyed;

  assign w_req       = {car_req, tower_req, erase_req};
  assign w_owner_req = w_req[r_owner];
  assign w_accept    = (r_state == ST_BURST) && w_owner_req;

  assign erase_ack = w_accept && (r_owner == SRC_ERASE);
  assign tower_ack = w_accept && (r_owner == SRC_TOWER);
  assign car_ack   = w_accept && (r_owner == SRC_CAR);

  // While a burst is closing, the finished owner is the rotation point.
  assign w_rr_last = (r_state == ST_BURST) ? r_owner : r_last_owner;

  rr_arbiter3 u_rr (
    .i_req   (w_req),
    .i_last  (w_rr_last),
    .o_grant (w_grant),
    .o_valid (w_grant_valid)
  );

  assign w_grant_src = onehot_to_src(w_grant);

  always_comb begin
    w_in_coord  = erase_coord;
    w_in_colour = '0;
    case (r_owner)
      SRC_TOWER: begin
        w_in_coord  = tower_coord;
        w_in_colour = tower_colour;
      end
      SRC_CAR: begin
        w_in_coord  = car_coord;
        w_in_colour = car_colour;
      end
      default: begin
        w_in_coord  = erase_coord;
        w_in_colour = '0;
      end
    endcase
  end

  assign w_in_range = in_range(w_in_coord);

`ifdef VGA_DRAW_ARB_TRANSPARENT_EN
  assign w_keyed = (r_owner != SRC_ERASE) && (w_in_colour == TRANSPARENT_COLOUR);
`else
  assign w_keyed = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= SRC_ERASE;
      r_last_owner <= SRC_CAR;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arb_enable && w_grant_valid) begin
            r_owner <= w_grant_src;
            r_state <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (!w_owner_req) begin
            r_last_owner <= r_owner;
            if (arb_enable && w_grant_valid) begin
              r_owner <= w_grant_src;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The RAM read is launched the cycle after acceptance so mem_q lines up with stage 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_add <= '0;
    end else if (w_accept && (r_owner == SRC_ERASE) && w_in_range) begin
      r_mem_add <= bg_addr(w_in_coord);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1.valid  <= w_accept && w_in_range && !w_keyed;
      r_s1.src    <= r_owner;
      r_s1.coord  <= w_in_coord;
      r_s1.colour <= w_in_colour;
      r_s2        <= r_s1;
    end
  end

  assign mem_add          = r_mem_add;
  assign coordinates      = r_s2.coord;
  assign VGA_write_enable = r_s2.valid;
  assign colours          = (r_s2.valid && (r_s2.src == SRC_ERASE)) ? mem_q : r_s2.colour;
  assign busy             = (r_state == ST_BURST) | r_s1.valid | r_s2.valid;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Scoreboard bench for vga_draw_arbiter: drawer models feed pixels, a monitor checks writes.
module tb_vga_draw_arbiter;
  import vga_draw_pkg::*;

  typedef struct packed {
    logic [14:0] coord;
    logic [8:0]  colour;
  } pix_t;

  typedef struct {
    logic [14:0] coord;
    logic [8:0]  colour;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, arb_enable;
  logic        erase_req, tower_req, car_req;
  logic [14:0] erase_coord, tower_coord, car_coord;
  logic [8:0]  tower_colour, car_colour;
  logic        erase_ack, tower_ack, car_ack;
  logic [14:0] mem_add;
  logic [8:0]  mem_q;
  logic [14:0] coordinates;
  logic [8:0]  colours;
  logic        VGA_write_enable, busy;

  int   cyc = 0;
  int   nChecks = 0;
  int   nFails = 0;
  logic rstNext, enNext;
  int   s, e;

  pix_t eraseQ[$];
  pix_t towerQ[$];
  pix_t carQ[$];
  int   eraseAcks[$];
  int   towerAcks[$];
  int   carAcks[$];
  exp_t sb[$];

  vga_draw_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .arb_enable       (arb_enable),
    .erase_req        (erase_req),
    .tower_req        (tower_req),
    .car_req          (car_req),
    .erase_coord      (erase_coord),
    .tower_coord      (tower_coord),
    .car_coord        (car_coord),
    .tower_colour     (tower_colour),
    .car_colour       (car_colour),
    .erase_ack        (erase_ack),
    .tower_ack        (tower_ack),
    .car_ack          (car_ack),
    .mem_add          (mem_add),
    .mem_q            (mem_q),
    .coordinates      (coordinates),
    .colours          (colours),
    .VGA_write_enable (VGA_write_enable),
    .busy             (busy)
  );

  function automatic logic [8:0] ramModel(input logic [14:0] a);
    return a[8:0] ^ 9'h15A;
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_q <= ramModel(mem_add);

  function automatic pix_t pix(input int x, input int y, input logic [8:0] c);
    pix_t p;
    p.coord  = {y[6:0], x[7:0]};
    p.colour = c;
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushExpected(input int src, input pix_t p);
    int   x = int'(p.coord[7:0]);
    int   y = int'(p.coord[14:8]);
    bit   keyed = 1'b0;
    exp_t ex;
`ifdef VGA_DRAW_ARB_TRANSPARENT_EN
    keyed = (src != 0) && (p.colour == 9'h1C7);
`endif
    if (x < 160 && y < 120 && !keyed) begin
      ex.coord  = p.coord;
      ex.colour = (src == 0) ? ramModel(15'(y * 160 + x)) : p.colour;
      ex.due    = cyc + 2;
      sb.push_back(ex);
    end
  endtask

  task automatic spuriousAck(input string name);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s: got ack=1 with no request, required ack=0 (cycle %0d)", name, cyc);
  endtask

  // Acks are sampled mid-cycle; an acked pixel is retired and its write is expected two cycles later.
  task automatic sampleAcks();
    if (erase_ack === 1'b1) begin
      if (eraseQ.size() > 0) begin
        pushExpected(0, eraseQ.pop_front());
        eraseAcks.push_back(cyc);
      end else spuriousAck("erase_ack");
    end
    if (tower_ack === 1'b1) begin
      if (towerQ.size() > 0) begin
        pushExpected(1, towerQ.pop_front());
        towerAcks.push_back(cyc);
      end else spuriousAck("tower_ack");
    end
    if (car_ack === 1'b1) begin
      if (carQ.size() > 0) begin
        pushExpected(2, carQ.pop_front());
        carAcks.push_back(cyc);
      end else spuriousAck("car_ack");
    end
  endtask

  task automatic applyStimulus();
    reset        = rstNext;
    arb_enable   = enNext;
    erase_req    = (eraseQ.size() > 0);
    erase_coord  = erase_req ? eraseQ[0].coord : 15'd0;
    tower_req    = (towerQ.size() > 0);
    tower_coord  = tower_req ? towerQ[0].coord : 15'd0;
    tower_colour = tower_req ? towerQ[0].colour : 9'd0;
    car_req      = (carQ.size() > 0);
    car_coord    = car_req ? carQ[0].coord : 15'd0;
    car_colour   = car_req ? carQ[0].colour : 9'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    applyStimulus();
    @(negedge clk);
    sampleAcks();
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, " erase_ack"}, erase_ack, 0);
    checkOutput({name, " tower_ack"}, tower_ack, 0);
    checkOutput({name, " car_ack"}, car_ack, 0);
    checkOutput({name, " write_enable"}, VGA_write_enable, 0);
    checkOutput({name, " coordinates"}, coordinates, 0);
    checkOutput({name, " colours"}, colours, 0);
    checkOutput({name, " mem_add"}, mem_add, 0);
    checkOutput({name, " busy"}, busy, 0);
  endtask

  task automatic clearLogs();
    eraseAcks.delete();
    towerAcks.delete();
    carAcks.delete();
  endtask

  // Monitor: every write must match the oldest expected pixel, on its due cycle.
  initial begin : monitor
    exp_t ex;
    forever begin
      @(negedge clk);
      if (VGA_write_enable === 1'b1) begin
        if (sb.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected write: got coord %0h colour %0h, required no write (cycle %0d)", coordinates, colours, cyc);
        end else begin
          ex = sb.pop_front();
          checkOutput("write coord", coordinates, ex.coord);
          checkOutput("write colour", colours, ex.colour);
          checkOutput("write cycle", cyc, ex.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        ex = sb.pop_front();
        nChecks++;
        nFails++;
        $display("[TB] FAIL missing write: got none at cycle %0d, required coord %0h", cyc, ex.coord);
      end
    end
  end

  initial begin
    reset = 1'b1; arb_enable = 1'b0;
    erase_req = 1'b0; tower_req = 1'b0; car_req = 1'b0;
    erase_coord = '0; tower_coord = '0; car_coord = '0;
    tower_colour = '0; car_colour = '0;
    rstNext = 1'b1; enNext = 1'b1;

    $display("[TB] power-on reset");
    step(); step();
    checkIdle("reset");
    rstNext = 1'b0;
    step();

    $display("[TB] reset in the middle of a tower burst");
    clearLogs();
    for (int i = 0; i < 5; i++) towerQ.push_back(pix(20 + i, 30, 9'h0AA));
    step(); step();
    rstNext = 1'b1;
    step();
    sb.delete();
    step();
    checkIdle("mid-burst reset");
    step();
    towerQ.delete();
    rstNext = 1'b0;
    repeat (6) step();
    checkOutput("acks before reset", towerAcks.size(), 2);

    $display("[TB] single tower burst");
    clearLogs();
    for (int i = 0; i < 4; i++) towerQ.push_back(pix(i, 10, 9'h1C0));
    step();
    s = cyc;
    step(); step();
    checkOutput("busy during burst", busy, 1);
    repeat (6) step();
    checkOutput("tower ack count", towerAcks.size(), 4);
    for (int i = 0; i < towerAcks.size(); i++) checkOutput("tower ack cycle", towerAcks[i], s + 1 + i);

    $display("[TB] erase pixel restores from background");
    clearLogs();
    eraseQ.push_back(pix(5, 2, 9'h000));
    step();
    s = cyc;
    step(); step();
    checkOutput("erase mem_add", mem_add, 325);
    repeat (4) step();
    checkOutput("erase ack count", eraseAcks.size(), 1);
    for (int i = 0; i < eraseAcks.size(); i++) checkOutput("erase ack cycle", eraseAcks[i], s + 1);

    $display("[TB] three simultaneous requesters after reset");
    rstNext = 1'b1;
    step();
    rstNext = 1'b0;
    step();
    clearLogs();
    for (int i = 0; i < 3; i++) begin
      eraseQ.push_back(pix(10 + i, 50, 9'h000));
      towerQ.push_back(pix(30 + i, 60, 9'h038));
      carQ.push_back(pix(100 + i, 119, 9'h007));
    end
    step();
    s = cyc;
    repeat (16) step();
    checkOutput("rr erase count", eraseAcks.size(), 3);
    checkOutput("rr tower count", towerAcks.size(), 3);
    checkOutput("rr car count", carAcks.size(), 3);
    for (int i = 0; i < eraseAcks.size(); i++) checkOutput("rr erase cycle", eraseAcks[i], s + 1 + i);
    for (int i = 0; i < towerAcks.size(); i++) checkOutput("rr tower cycle", towerAcks[i], s + 5 + i);
    for (int i = 0; i < carAcks.size(); i++) checkOutput("rr car cycle", carAcks[i], s + 9 + i);

    $display("[TB] out-of-range and colour-key pixels");
    clearLogs();
    carQ.push_back(pix(160, 0, 9'h155));
    carQ.push_back(pix(159, 119, 9'h0F0));
    towerQ.push_back(pix(7, 7, 9'h1C7));
    eraseQ.push_back(pix(0, 120, 9'h000));
    repeat (13) step();
    checkOutput("oor car ack count", carAcks.size(), 2);
    checkOutput("keyed tower ack count", towerAcks.size(), 1);
    checkOutput("oor erase ack count", eraseAcks.size(), 1);
    checkOutput("mem_add held", mem_add, 8012);

    $display("[TB] arbitration disabled while idle");
    clearLogs();
    enNext = 1'b0;
    for (int i = 0; i < 2; i++) carQ.push_back(pix(40 + i, 40, 9'h111));
    repeat (10) step();
    checkOutput("disabled car acks", carAcks.size(), 0);
    checkOutput("disabled busy", busy, 0);
    enNext = 1'b1;
    step();
    e = cyc;
    repeat (5) step();
    checkOutput("enabled car count", carAcks.size(), 2);
    for (int i = 0; i < carAcks.size(); i++) checkOutput("enabled car cycle", carAcks[i], e + 1 + i);

    $display("[TB] arbitration disabled mid-burst");
    clearLogs();
    for (int i = 0; i < 4; i++) towerQ.push_back(pix(50 + i, 20, 9'h0C3));
    step();
    s = cyc;
    step(); step();
    enNext = 1'b0;
    carQ.push_back(pix(60, 21, 9'h01C));
    repeat (8) step();
    checkOutput("burst finishes count", towerAcks.size(), 4);
    if (towerAcks.size() == 4) checkOutput("burst last ack", towerAcks[3], s + 4);
    checkOutput("no grant while disabled", carAcks.size(), 0);
    enNext = 1'b1;
    step();
    e = cyc;
    repeat (4) step();
    checkOutput("late car count", carAcks.size(), 1);
    for (int i = 0; i < carAcks.size(); i++) checkOutput("late car cycle", carAcks[i], e + 1);

    repeat (3) step();
    checkOutput("scoreboard drained", sb.size(), 0);
    checkOutput("final busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
